alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-port round-robin arbiter and sequencer that shares one combinational `alu8bit` instance (8-bit operands, 3-bit opcode, 8-bit result, 4-bit flags) between two requesters.
- Each requester presents an operation on a valid/ready port.
- The block grants one requester at a time, registers that requester's operands, and evaluates them through the internal `alu8bit`.
- The result and flags are returned on that requester's response port with valid/ready backpressure.
- The block sits between two independent datapath clients and the single ALU.

## Interface
- FAIR, default 1: 1 = round-robin between ports; 0 = fixed priority, port 0 always wins.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous and active-high.
- req0_valid / req1_valid  input  1  requester k has an operation pending.
- req0_ready / req1_ready  output  1  operation accepted this cycle when valid & ready.
- req0_a, req0_b / req1_a, req1_b  input  8  operands.
- req0_op / req1_op  input  3  ALU opcode: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 compare; 110/111 illegal.
- rsp0_valid / rsp1_valid  output  1  response k holds a result.
- rsp0_ready / rsp1_ready  input  1  requester k consumes the response.
- rsp_result  output  8  registered ALU result, shared by both response ports.
- rsp_flags  output  4  registered ALU flags, passed through unmodified.
- rsp_err  output  1  1 = opcode was illegal; result and flags forced to 0.
- busy  output  1  state != IDLE.
- ops_done  output  16  count of completed responses; wraps 0xFFFF -> 0x0000.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE
  - Grant is computed combinationally from req0_valid, req1_valid and last_grant.
  - Only one valid: that port wins.
  - Both valid with FAIR=1: the port != last_grant wins. With FAIR=0: port 0 wins.
  - Only the winner's req_ready is 1; the loser's req_ready stays 0.
  - On handshake: latch a, b, op and grant index; last_grant <= grant; go to EXEC.
  - No valid: stay in IDLE; both req_ready = 0.
- EXEC
  - The internal alu8bit is driven from the latched a, b, op.
  - Capture result and flags into the rsp registers; rsp_err = (op is 110 or 111).
  - Illegal op: rsp_result = 0x00, rsp_flags = 0x0.
  - Go to RESP.
- RESP
  - rsp_valid is asserted for the granted port only.
  - rsp_result, rsp_flags and rsp_err are held stable while rsp_valid = 1.
  - On rsp_valid & rsp_ready: ops_done += 1; go to IDLE.
  - While rsp_ready = 0: stay in RESP indefinitely.
- req_valid may drop without handshake; no operation is recorded.
- Operands are sampled only at the handshake. Changes to req_a, req_b or req_op afterwards do not affect the in-flight result.
- rsp_ready on the non-granted port is ignored.

## Timing
- Reset values:
  - state = IDLE, last_grant = 1 (port 0 wins the first contention).
  - req*_ready = 0, rsp*_valid = 0.
  - rsp_result = 0x00, rsp_flags = 0x0, rsp_err = 0, busy = 0, ops_done = 0x0000.
- req_ready is combinational from state, req valids and last_grant. It does not depend on req_a, req_b or req_op.
- Latency: handshake at edge T -> rsp_valid = 1 after edge T+2 (two cycles).
- Minimum issue interval: 3 cycles (handshake, EXEC, RESP with rsp_ready = 1).
- A new request is never accepted in the same cycle a response completes. IDLE is always visited for at least one cycle.
- Reset asserted mid-operation (EXEC or RESP): the in-flight operation is discarded, outputs return to reset values immediately (asynchronous), and ops_done does not increment.

## Test plan
- Reset, then port 0 only: a=0x01, b=0x01, op=000, rsp0_ready=1 -> req0_ready=1 at issue; rsp0_valid 2 cycles later; rsp_result=0x02, rsp_err=0, ops_done=1.
- Both ports hold valid for 4 operations, FAIR=1, port0 op=001 (0x01-0x01), port1 op=000 (0xFF+0x01) -> grants 0,1,0,1; port0 result 0x00 with zero flag set; port1 result 0x00 with carry set. Repeat with FAIR=0 -> port 0 granted every time.
- Backpressure: port 1 a=0x80, b=0x01, op=000, rsp1_ready held 0 for 5 cycles -> rsp1_valid held 1; rsp_result=0x81 stable; req0_ready=0 throughout despite req0_valid=1.
- Illegal op 111 on port 0 -> rsp_err=1, rsp_result=0x00, rsp_flags=0x0; ops_done increments.
- Assert rst while in RESP with rsp0_ready=0 -> all outputs at reset values on the same cycle; after release, the next grant goes to port 0 under contention.
- Preload ops_done to 0xFFFF via 65535 back-to-back operations, then complete one more -> ops_done=0x0000.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two ALU clients and the shared alu_arbiter.
// The master side is the pair of clients; the slave side is the arbiter.
interface alu_arbiter_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [7:0] req0_a;
  logic [7:0] req0_b;
  logic [2:0] req0_op;
  logic       req1_valid;
  logic       req1_ready;
  logic [7:0] req1_a;
  logic [7:0] req1_b;
  logic [2:0] req1_op;
  logic       rsp0_valid;
  logic       rsp0_ready;
  logic       rsp1_valid;
  logic       rsp1_ready;
  logic [7:0] rsp_result;
  logic [3:0] rsp_flags;
  logic       rsp_err;
  logic       busy;
  logic [15:0] ops_done;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    input  rsp_result, rsp_flags, rsp_err, busy, ops_done
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    output rsp_result, rsp_flags, rsp_err, busy, ops_done
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port arbiter that shares one combinational 8-bit ALU between two clients.
// Flags are {overflow, negative, carry/borrow, zero}; compare sets flags from a-b and returns 0.
module alu8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [2:0] op,
  output logic [7:0] result,
  output logic [3:0] flags,
  output logic       illegal
);
  logic [8:0] sum;
  logic [8:0] diff;
  logic [7:0] flag_src;
  logic       carry;
  logic       ovf;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    result   = 8'h00;
    flag_src = 8'h00;
    carry    = 1'b0;
    ovf      = 1'b0;
    illegal  = 1'b0;
    case (op)
      3'b000: begin
        result   = sum[7:0];
        flag_src = sum[7:0];
        carry    = sum[8];
        ovf      = (a[7] == b[7]) && (sum[7] != a[7]);
      end
      3'b001: begin
        result   = diff[7:0];
        flag_src = diff[7:0];
        carry    = diff[8];
        ovf      = (a[7] != b[7]) && (diff[7] != a[7]);
      end
      3'b010: begin
        result   = a & b;
        flag_src = a & b;
      end
      3'b011: begin
        result   = a | b;
        flag_src = a | b;
      end
      3'b100: begin
        result   = a ^ b;
        flag_src = a ^ b;
      end
      3'b101: begin
        flag_src = diff[7:0];
        carry    = diff[8];
        ovf      = (a[7] != b[7]) && (diff[7] != a[7]);
      end
      default: illegal = 1'b1;
    endcase
  end

  assign flags = illegal ? 4'h0 : {ovf, flag_src[7], carry, flag_src == 8'h00};
endmodule

module alu_arbiter #(
  parameter bit FAIR = 1'b1
) (
  input logic          clk,
  input logic          rst,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state;
  logic        last_grant;
  logic        grant;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [2:0]  op_q;
  logic [7:0]  result_q;
  logic [3:0]  flags_q;
  logic        err_q;
  logic        rsp0_q;
  logic        rsp1_q;
  logic        busy_q;
  logic [15:0] ops_cnt;

  logic        win1;
  logic        take0;
  logic        take1;
  logic        done;
  logic [7:0]  alu_result;
  logic [3:0]  alu_flags;
  logic        alu_illegal;

  // Port 1 wins only if it is alone, or under fair contention when port 0 went last.
  assign win1  = bus.req1_valid && (!bus.req0_valid || (FAIR && !last_grant));
  assign take0 = (state == IDLE) && bus.req0_valid && !win1;
  assign take1 = (state == IDLE) && win1;
  assign done  = (state == RESP) && (grant ? bus.rsp1_ready : bus.rsp0_ready);

  alu8bit u_alu (
    .a       (a_q),
    .b       (b_q),
    .op      (op_q),
    .result  (alu_result),
    .flags   (alu_flags),
    .illegal (alu_illegal)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      a_q        <= 8'h00;
      b_q        <= 8'h00;
      op_q       <= 3'b000;
      result_q   <= 8'h00;
      flags_q    <= 4'h0;
      err_q      <= 1'b0;
      rsp0_q     <= 1'b0;
      rsp1_q     <= 1'b0;
      busy_q     <= 1'b0;
      ops_cnt    <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (take0 || take1) begin
            a_q        <= take1 ? bus.req1_a  : bus.req0_a;
            b_q        <= take1 ? bus.req1_b  : bus.req0_b;
            op_q       <= take1 ? bus.req1_op : bus.req0_op;
            grant      <= take1;
            last_grant <= take1;
            busy_q     <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          result_q <= alu_result;
          flags_q  <= alu_flags;
          err_q    <= alu_illegal;
          rsp0_q   <= !grant;
          rsp1_q   <= grant;
          state    <= RESP;
        end
        RESP: begin
          if (done) begin
            rsp0_q  <= 1'b0;
            rsp1_q  <= 1'b0;
            busy_q  <= 1'b0;
            ops_cnt <= ops_cnt + 16'd1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req0_ready = take0;
  assign bus.req1_ready = take1;
  assign bus.rsp0_valid = rsp0_q;
  assign bus.rsp1_valid = rsp1_q;
  assign bus.rsp_result = result_q;
  assign bus.rsp_flags  = flags_q;
  assign bus.rsp_err    = err_q;
  assign bus.busy       = busy_q;
  assign bus.ops_done   = ops_cnt;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one round-robin and one fixed-priority instance
// share the same stimulus; flags are {overflow, negative, carry, zero}.
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic       r0_valid = 1'b0, r1_valid = 1'b0;
  logic [7:0] r0_a = 8'h00, r0_b = 8'h00, r1_a = 8'h00, r1_b = 8'h00;
  logic [2:0] r0_op = 3'b000, r1_op = 3'b000;
  logic       s0_ready = 1'b0, s1_ready = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_arbiter_if bus_f ();
  alu_arbiter_if bus_p ();

  assign bus_f.req0_valid = r0_valid;
  assign bus_f.req0_a     = r0_a;
  assign bus_f.req0_b     = r0_b;
  assign bus_f.req0_op    = r0_op;
  assign bus_f.req1_valid = r1_valid;
  assign bus_f.req1_a     = r1_a;
  assign bus_f.req1_b     = r1_b;
  assign bus_f.req1_op    = r1_op;
  assign bus_f.rsp0_ready = s0_ready;
  assign bus_f.rsp1_ready = s1_ready;
  assign bus_p.req0_valid = r0_valid;
  assign bus_p.req0_a     = r0_a;
  assign bus_p.req0_b     = r0_b;
  assign bus_p.req0_op    = r0_op;
  assign bus_p.req1_valid = r1_valid;
  assign bus_p.req1_a     = r1_a;
  assign bus_p.req1_b     = r1_b;
  assign bus_p.req1_op    = r1_op;
  assign bus_p.rsp0_ready = s0_ready;
  assign bus_p.rsp1_ready = s1_ready;

  alu_arbiter #(.FAIR(1'b1)) u_fair (.clk(clk), .rst(rst), .bus(bus_f));
  alu_arbiter #(.FAIR(1'b0)) u_prio (.clk(clk), .rst(rst), .bus(bus_p));

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_req0_ready", 16'(bus_f.req0_ready), 16'h0);
    check("rst_req1_ready", 16'(bus_f.req1_ready), 16'h0);
    check("rst_rsp0_valid", 16'(bus_f.rsp0_valid), 16'h0);
    check("rst_rsp1_valid", 16'(bus_f.rsp1_valid), 16'h0);
    check("rst_result", 16'(bus_f.rsp_result), 16'h00);
    check("rst_flags", 16'(bus_f.rsp_flags), 16'h0);
    check("rst_err", 16'(bus_f.rsp_err), 16'h0);
    check("rst_busy", 16'(bus_f.busy), 16'h0);
    check("rst_ops_done", bus_f.ops_done, 16'h0000);
    rst = 1'b0;

    // Port 0 alone: 0x01 + 0x01
    r0_valid = 1'b1; r0_a = 8'h01; r0_b = 8'h01; r0_op = 3'b000; s0_ready = 1'b1;
    settle();
    check("p0_req0_ready", 16'(bus_f.req0_ready), 16'h1);
    check("p0_req1_ready", 16'(bus_f.req1_ready), 16'h0);
    tick();
    r0_valid = 1'b0;
    settle();
    check("p0_exec_rsp0_valid", 16'(bus_f.rsp0_valid), 16'h0);
    check("p0_exec_busy", 16'(bus_f.busy), 16'h1);
    tick();
    check("p0_rsp0_valid", 16'(bus_f.rsp0_valid), 16'h1);
    check("p0_rsp1_valid", 16'(bus_f.rsp1_valid), 16'h0);
    check("p0_result", 16'(bus_f.rsp_result), 16'h02);
    check("p0_flags", 16'(bus_f.rsp_flags), 16'h0);
    check("p0_err", 16'(bus_f.rsp_err), 16'h0);
    tick();
    check("p0_done_rsp0_valid", 16'(bus_f.rsp0_valid), 16'h0);
    check("p0_done_busy", 16'(bus_f.busy), 16'h0);
    check("p0_ops_done", bus_f.ops_done, 16'h0001);

    // Contention from reset: fair grants 0,1,0,1; fixed priority always 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    r0_valid = 1'b1; r0_a = 8'h01; r0_b = 8'h01; r0_op = 3'b001; s0_ready = 1'b1;
    r1_valid = 1'b1; r1_a = 8'hFF; r1_b = 8'h01; r1_op = 3'b000; s1_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic g;
      g = 1'(i % 2);
      settle();
      check($sformatf("fair_req0_ready_%0d", i), 16'(bus_f.req0_ready), 16'(!g));
      check($sformatf("fair_req1_ready_%0d", i), 16'(bus_f.req1_ready), 16'(g));
      check($sformatf("prio_req0_ready_%0d", i), 16'(bus_p.req0_ready), 16'h1);
      check($sformatf("prio_req1_ready_%0d", i), 16'(bus_p.req1_ready), 16'h0);
      tick();
      tick();
      check($sformatf("fair_rsp0_valid_%0d", i), 16'(bus_f.rsp0_valid), 16'(!g));
      check($sformatf("fair_rsp1_valid_%0d", i), 16'(bus_f.rsp1_valid), 16'(g));
      check($sformatf("fair_result_%0d", i), 16'(bus_f.rsp_result), 16'h00);
      check($sformatf("fair_flags_%0d", i), 16'(bus_f.rsp_flags), g ? 16'h3 : 16'h1);
      check($sformatf("prio_rsp0_valid_%0d", i), 16'(bus_p.rsp0_valid), 16'h1);
      check($sformatf("prio_flags_%0d", i), 16'(bus_p.rsp_flags), 16'h1);
      tick();
    end
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    settle();
    check("cont_fair_ops_done", bus_f.ops_done, 16'h0004);
    check("cont_prio_ops_done", bus_p.ops_done, 16'h0004);

    // Backpressure on port 1: 0x80 + 0x01 held for 5 cycles
    r1_valid = 1'b1; r1_a = 8'h80; r1_b = 8'h01; r1_op = 3'b000; s1_ready = 1'b0;
    settle();
    check("bp_req1_ready", 16'(bus_f.req1_ready), 16'h1);
    tick();
    r1_valid = 1'b0;
    r0_valid = 1'b1; r0_a = 8'h55; r0_b = 8'hAA; r0_op = 3'b111; s0_ready = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_rsp1_valid_%0d", i), 16'(bus_f.rsp1_valid), 16'h1);
      check($sformatf("bp_rsp0_valid_%0d", i), 16'(bus_f.rsp0_valid), 16'h0);
      check($sformatf("bp_result_%0d", i), 16'(bus_f.rsp_result), 16'h81);
      check($sformatf("bp_flags_%0d", i), 16'(bus_f.rsp_flags), 16'h4);
      check($sformatf("bp_req0_ready_%0d", i), 16'(bus_f.req0_ready), 16'h0);
      tick();
    end
    s1_ready = 1'b1;
    tick();
    check("bp_rsp1_valid_after", 16'(bus_f.rsp1_valid), 16'h0);
    check("bp_ops_done", bus_f.ops_done, 16'h0005);

    // Illegal opcode 111 on port 0; opcode changes after the handshake are ignored
    check("ill_req0_ready", 16'(bus_f.req0_ready), 16'h1);
    tick();
    r0_valid = 1'b0; r0_op = 3'b000;
    tick();
    check("ill_rsp0_valid", 16'(bus_f.rsp0_valid), 16'h1);
    check("ill_err", 16'(bus_f.rsp_err), 16'h1);
    check("ill_result", 16'(bus_f.rsp_result), 16'h00);
    check("ill_flags", 16'(bus_f.rsp_flags), 16'h0);
    tick();
    check("ill_ops_done", bus_f.ops_done, 16'h0006);

    // Reset while in RESP with the response stalled
    r0_valid = 1'b1; r0_a = 8'h03; r0_b = 8'h04; r0_op = 3'b000; s0_ready = 1'b0;
    tick();
    r0_valid = 1'b0;
    tick();
    check("mid_rsp0_valid", 16'(bus_f.rsp0_valid), 16'h1);
    check("mid_result", 16'(bus_f.rsp_result), 16'h07);
    rst = 1'b1;
    settle();
    check("mid_rst_rsp0_valid", 16'(bus_f.rsp0_valid), 16'h0);
    check("mid_rst_result", 16'(bus_f.rsp_result), 16'h00);
    check("mid_rst_busy", 16'(bus_f.busy), 16'h0);
    check("mid_rst_ops_done", bus_f.ops_done, 16'h0000);
    tick();
    rst = 1'b0;
    r0_valid = 1'b1; r1_valid = 1'b1; s0_ready = 1'b1; s1_ready = 1'b1;
    r1_a = 8'h00; r1_b = 8'h00; r1_op = 3'b000;
    settle();
    check("post_rst_req0_ready", 16'(bus_f.req0_ready), 16'h1);
    check("post_rst_req1_ready", 16'(bus_f.req1_ready), 16'h0);
    tick();
    r0_valid = 1'b0; r1_valid = 1'b0;
    tick();
    check("post_rst_rsp0_valid", 16'(bus_f.rsp0_valid), 16'h1);
    check("post_rst_result", 16'(bus_f.rsp_result), 16'h07);
    tick();
    check("post_rst_ops_done", bus_f.ops_done, 16'h0001);

    // Counter wrap: preload to 0xFFFF, then a compare 0x03 vs 0x05
    force u_fair.ops_cnt = 16'hFFFF;
    #1;
    release u_fair.ops_cnt;
    #1;
    check("wrap_preload", bus_f.ops_done, 16'hFFFF);
    tick();
    r0_valid = 1'b1; r0_a = 8'h03; r0_b = 8'h05; r0_op = 3'b101;
    tick();
    r0_valid = 1'b0;
    tick();
    check("cmp_result", 16'(bus_f.rsp_result), 16'h00);
    check("cmp_flags", 16'(bus_f.rsp_flags), 16'h6);
    tick();
    check("wrap_ops_done", bus_f.ops_done, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
